// File: rtl/player_motion.sv
// Per-frame player kinematics: keycode-driven walk/jump under gravity,
// clamped to the screen walls, ceiling and floor. Updates once per frame tick.
module player_motion #(
    parameter int X_START  = 320,
    parameter int FLOOR_Y  = 400,
    parameter int SIZE     = 16,
    parameter int X_MAX    = 639,
    parameter int HSPEED   = 3,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int MAX_FALL = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] PlayerX,
    output logic [9:0] PlayerY,
    output logic [9:0] PlayerS,
    output logic       Grounded
);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    localparam logic signed [10:0] X_LO    = 11'(SIZE);
    localparam logic signed [10:0] X_HI    = 11'(X_MAX - SIZE);
    localparam logic signed [10:0] HSPD11  = 11'(HSPEED);
    localparam logic signed [10:0] SIZE11  = 11'(SIZE);
    localparam logic signed [10:0] FLOOR11 = 11'(FLOOR_Y);
    localparam logic signed [9:0]  JUMP10  = 10'(JUMP_V);
    localparam logic signed [9:0]  GRAV10  = 10'(GRAVITY);
    localparam logic signed [9:0]  MAXF10  = 10'(MAX_FALL);
    localparam logic [9:0]         Y_REST  = 10'(FLOOR_Y - SIZE);

    logic              r_s1, r_s2, r_s3;
    logic [9:0]        r_x, r_y;
    logic signed [9:0] r_vy;
    state_t            r_state;
    logic              r_grnd;

    logic              w_tick, w_left, w_right, w_jump;
    logic signed [10:0] w_x_new, w_x_nx;
    logic signed [9:0]  w_vy_sum, w_vy_n, w_vy_nx;
    logic signed [10:0] w_y_n, w_y_top, w_y_bot;
    logic [9:0]         w_y_nx;
    state_t             w_st_nx;

    assign w_tick  = r_s2 & ~r_s3;
    assign w_left  = (keycode == 8'h04);
    assign w_right = (keycode == 8'h07);
    assign w_jump  = (keycode == 8'h1A) || (keycode == 8'h2C);

    always_comb begin
        w_x_new = $signed({1'b0, r_x});
        if (w_left)
            w_x_new = $signed({1'b0, r_x}) - HSPD11;
        else if (w_right)
            w_x_new = $signed({1'b0, r_x}) + HSPD11;
        if (w_x_new < X_LO)
            w_x_nx = X_LO;
        else if (w_x_new > X_HI)
            w_x_nx = X_HI;
        else
            w_x_nx = w_x_new;
    end

    // Airborne step: capped velocity first, then position from the new velocity.
    always_comb begin
        w_vy_sum = r_vy + GRAV10;
        w_vy_n   = (w_vy_sum > MAXF10) ? MAXF10 : w_vy_sum;
        w_y_n    = $signed({1'b0, r_y}) + $signed({w_vy_n[9], w_vy_n});
        w_y_top  = w_y_n - SIZE11;
        w_y_bot  = w_y_n + SIZE11;
        w_y_nx   = r_y;
        w_vy_nx  = r_vy;
        w_st_nx  = r_state;
        if (r_state == GROUND) begin
            w_vy_nx = 10'sd0;
            if (w_jump) begin
                w_vy_nx = -JUMP10;
                w_y_nx  = r_y - 10'(JUMP_V);
                w_st_nx = RISE;
            end
        end else begin
            w_vy_nx = w_vy_n;
            w_y_nx  = w_y_n[9:0];
            w_st_nx = (r_state == RISE && w_vy_n[9]) ? RISE : FALL;
            if (w_y_top[10]) begin
                w_y_nx  = 10'(SIZE);
                w_vy_nx = 10'sd0;
                w_st_nx = FALL;
            end
            if (w_y_bot >= FLOOR11) begin
                w_y_nx  = Y_REST;
                w_vy_nx = 10'sd0;
                w_st_nx = GROUND;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_s1    <= 1'b0;
            r_s2    <= 1'b0;
            r_s3    <= 1'b0;
            r_x     <= 10'(X_START);
            r_y     <= Y_REST;
            r_vy    <= 10'sd0;
            r_state <= GROUND;
            r_grnd  <= 1'b1;
        end else begin
            r_s1 <= frame_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (w_tick) begin
                r_x     <= w_x_nx[9:0];
                r_y     <= w_y_nx;
                r_vy    <= w_vy_nx;
                r_state <= w_st_nx;
                r_grnd  <= (w_st_nx == GROUND);
            end
        end
    end

    assign PlayerX  = r_x;
    assign PlayerY  = r_y;
    assign PlayerS  = 10'(SIZE);
    assign Grounded = r_grnd;

endmodule

// File: tb/tb_player_motion.sv
// Directed-vector bench for player_motion: reset, walk, wall clamp, jump arc,
// no double jump, tick-edge reset and held frame_clk.
module tb_player_motion;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] PlayerX, PlayerY, PlayerS;
    logic       Grounded;

    int n_vec = 0;
    int n_err = 0;

    logic [9:0] ex, ey;
    logic       eg;

    localparam int ARC_N = 27;
    localparam int ARC [ARC_N] = '{372, 361, 351, 342, 334, 327, 321, 316, 312,
                                   309, 307, 306, 306, 307, 309, 312, 316, 321,
                                   327, 334, 342, 350, 358, 366, 374, 382, 384};

    player_motion dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .frame_clk(frame_clk),
        .keycode  (keycode),
        .PlayerX  (PlayerX),
        .PlayerY  (PlayerY),
        .PlayerS  (PlayerS),
        .Grounded (Grounded)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // One frame: key held through the tick, 'idle' applied between ticks.
    task automatic frame(input logic [7:0] key, input logic [7:0] idle,
                         input logic [9:0] nx, input logic [9:0] ny, input logic ng);
        @(negedge Clk);
        keycode   = key;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        chk("hold_x", PlayerX, ex);
        chk("hold_y", PlayerY, ey);
        @(negedge Clk);
        chk("upd_x", PlayerX, nx);
        chk("upd_y", PlayerY, ny);
        chk("upd_g", {9'd0, Grounded}, {9'd0, ng});
        ex = nx;
        ey = ny;
        eg = ng;
        keycode   = idle;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    initial begin
        Reset     = 1'b0;
        frame_clk = 1'b0;
        keycode   = 8'h00;
        ex = 10'd320; ey = 10'd384; eg = 1'b1;

        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        repeat (8) @(negedge Clk);
        chk("rst_x", PlayerX, 10'd320);
        chk("rst_y", PlayerY, 10'd384);
        chk("rst_s", PlayerS, 10'd16);
        chk("rst_g", {9'd0, Grounded}, 10'd1);

        for (int i = 1; i <= 5; i++)
            frame(8'h07, 8'h00, 10'(320 + 3 * i), 10'd384, 1'b1);

        // frame_clk held high: a single update only
        @(negedge Clk);
        keycode   = 8'h07;
        frame_clk = 1'b1;
        repeat (12) @(negedge Clk);
        chk("held_x", PlayerX, 10'd338);
        keycode   = 8'h00;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        ex = 10'd338;

        for (int i = 0; i < 106; i++)
            frame(8'h04, 8'h00, ex - 10'd3, 10'd384, 1'b1);
        chk("at20_x", PlayerX, 10'd20);
        frame(8'h04, 8'h00, 10'd17, 10'd384, 1'b1);
        frame(8'h04, 8'h00, 10'd16, 10'd384, 1'b1);
        frame(8'h04, 8'h00, 10'd16, 10'd384, 1'b1);

        // Jump arc; right key between ticks must be ignored
        for (int i = 0; i < ARC_N; i++)
            frame((i == 0) ? 8'h2C : 8'h00, 8'h07, 10'd16, 10'(ARC[i]), i == ARC_N - 1);

        // W held every frame: same arc, then a fresh jump after landing
        for (int i = 0; i < ARC_N; i++)
            frame(8'h1A, 8'h07, 10'd16, 10'(ARC[i]), i == ARC_N - 1);
        frame(8'h1A, 8'h00, 10'd16, 10'd372, 1'b0);
        frame(8'h00, 8'h00, 10'd16, 10'd361, 1'b0);
        frame(8'h00, 8'h00, 10'd16, 10'd351, 1'b0);
        frame(8'h00, 8'h00, 10'd16, 10'd342, 1'b0);
        frame(8'h00, 8'h00, 10'd16, 10'd334, 1'b0);

        // Reset asserted on the tick cycle mid-jump
        @(negedge Clk);
        keycode   = 8'h07;
        frame_clk = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rtick_x", PlayerX, 10'd320);
        chk("rtick_y", PlayerY, 10'd384);
        chk("rtick_g", {9'd0, Grounded}, 10'd1);
        frame_clk = 1'b0;
        keycode   = 8'h00;
        @(negedge Clk);
        Reset = 1'b1;
        repeat (6) @(negedge Clk);
        chk("post_x", PlayerX, 10'd320);
        chk("post_y", PlayerY, 10'd384);
        ex = 10'd320; ey = 10'd384; eg = 1'b1;
        frame(8'h07, 8'h00, 10'd323, 10'd384, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
